// File: rtl/score_disp_ctrl_pkg.sv
// Shared definitions for the score counter / multiplexed 7-segment display:
// segment encoding, blank code, parameter legal limits and BCD helpers.
package score_disp_ctrl_pkg;

    typedef logic [3:0] bcd_t;

    typedef enum logic {
        OVF_WRAP = 1'b0,
        OVF_SAT  = 1'b1
    } ovf_mode_e;

    // Parameter legal limits
    localparam int unsigned NUM_DIGITS_MIN = 1;
    localparam int unsigned NUM_DIGITS_MAX = 8;
    localparam int unsigned STROBE_DIV_MIN = 2;
    localparam int unsigned WIN_SCORE_MIN  = 1;

    // Active-low code that turns every segment and the dot off
    localparam logic [7:0] SEG_BLANK = 8'hFF;

    // Active-low segment table, bit 7 = dot (kept off), bits 6:0 = g..a
    function automatic logic [7:0] seg_encode(input bcd_t d);
        logic [7:0] seg;
        case (d)
            4'd0:    seg = 8'b1100_0000;
            4'd1:    seg = 8'b1111_1001;
            4'd2:    seg = 8'b1010_0100;
            4'd3:    seg = 8'b1011_0000;
            4'd4:    seg = 8'b1001_1001;
            4'd5:    seg = 8'b1001_0010;
            4'd6:    seg = 8'b1000_0010;
            4'd7:    seg = 8'b1111_1000;
            4'd8:    seg = 8'b1000_0000;
            4'd9:    seg = 8'b1001_0000;
            default: seg = SEG_BLANK;
        endcase
        return seg;
    endfunction

    // Largest score representable with nd BCD digits
    function automatic int unsigned win_score_max(input int unsigned nd);
        int unsigned m;
        m = 1;
        for (int unsigned i = 0; i < nd; i++) begin
            m = m * 10;
        end
        return m - 1;
    endfunction

    // Binary to packed BCD, up to NUM_DIGITS_MAX digits, units in [3:0]
    function automatic logic [31:0] to_bcd(input int unsigned value);
        logic [31:0] r;
        int unsigned v;
        r = '0;
        v = value;
        for (int unsigned i = 0; i < NUM_DIGITS_MAX; i++) begin
            r[4*i +: 4] = 4'(v % 10);
            v = v / 10;
        end
        return r;
    endfunction

endpackage

// File: rtl/score_disp_ctrl_digit.sv
// Single decade (0..9) counter stage of the BCD score chain.
module bcd_digit_cnt
    import score_disp_ctrl_pkg::*;
(
    input  logic clk_i,
    input  logic rst_i,
    input  logic clear_i,
    input  logic carry_i,
    input  logic hold_i,
    output bcd_t digit_o,
    output logic carry_o
);

    bcd_t digit_q;
    bcd_t digit_d;

    // Next digit: advance on carry-in unless the whole score is saturated
    always_comb begin
        digit_d = digit_q;
        if (carry_i && !hold_i) begin
            digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
        end
    end

    // Digit register; reset beats clear, clear beats counting
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            digit_q <= '0;
        end else if (clear_i) begin
            digit_q <= '0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit_o = digit_q;
    assign carry_o = carry_i && (digit_q == 4'd9);

endmodule

// File: rtl/score_disp_ctrl.sv
// Snake score keeper: edge-detected BCD score counter with win/overflow
// flags, driving a time-multiplexed active-low 7-segment display.
module score_disp_ctrl
    import score_disp_ctrl_pkg::*;
#(
    parameter int unsigned NUM_DIGITS = 4,
    parameter int unsigned STROBE_DIV = 100000,
    parameter int unsigned WIN_SCORE  = 10,
    parameter int unsigned SAT_MODE   = 0,
    parameter int unsigned BLANK_LZ   = 1
) (
    input  logic                    CLK,
    input  logic                    RESET,
    input  logic                    TARGET_ATE,
    input  logic                    CLEAR,
    output logic [4*NUM_DIGITS-1:0] SCORE_BCD,
    output logic                    WIN,
    output logic                    OVF,
    output logic [NUM_DIGITS-1:0]   SEG_SELECT_OUT,
    output logic [7:0]              HEX_OUT
);

    localparam int unsigned CNT_W = (STROBE_DIV > 1) ? $clog2(STROBE_DIV) : 1;
    localparam int unsigned IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam ovf_mode_e   MODE  = (SAT_MODE != 0) ? OVF_SAT : OVF_WRAP;
    // Score one below the win score: WIN rises as this value is incremented,
    // so it lands on the same edge as the score reaching WIN_SCORE.
    localparam logic [31:0] WIN_PREV_BCD = to_bcd(WIN_SCORE - 1);

    logic                    ate_q;
    logic                    inc;
    logic                    top_carry;
    logic                    sat_hold;
    logic [4*NUM_DIGITS-1:0] score;
    logic                    win_q;
    logic                    ovf_q;

    assign inc       = TARGET_ATE && !ate_q;
    assign top_carry = g_digit[NUM_DIGITS-1].cout;
    assign sat_hold  = (MODE == OVF_SAT) && top_carry;

    // Decade counter chain; carry ripples combinationally within one cycle
    for (genvar i = 0; i < NUM_DIGITS; i++) begin : g_digit
        logic cin;
        logic cout;
        bcd_t digit;

        if (i == 0) begin : g_first
            assign cin = inc;
        end else begin : g_next
            assign cin = g_digit[i-1].cout;
        end

        bcd_digit_cnt u_cnt (
            .clk_i   (CLK),
            .rst_i   (RESET),
            .clear_i (CLEAR),
            .carry_i (cin),
            .hold_i  (sat_hold),
            .digit_o (digit),
            .carry_o (cout)
        );

        assign score[4*i +: 4] = digit;
    end

    // Edge register and sticky win / one-cycle overflow flags
    always_ff @(posedge CLK) begin
        if (RESET) begin
            ate_q <= 1'b0;
            win_q <= 1'b0;
            ovf_q <= 1'b0;
        end else begin
            ate_q <= TARGET_ATE;
            if (CLEAR) begin
                win_q <= 1'b0;
                ovf_q <= 1'b0;
            end else begin
                win_q <= win_q || (inc && (score == WIN_PREV_BCD[4*NUM_DIGITS-1:0]));
                ovf_q <= top_carry && (MODE == OVF_WRAP);
            end
        end
    end

    logic [CNT_W-1:0]      cnt_q;
    logic [CNT_W-1:0]      cnt_d;
    logic [IDX_W-1:0]      idx_q;
    logic [IDX_W-1:0]      idx_d;
    logic [NUM_DIGITS-1:0] seg_q;
    logic [NUM_DIGITS-1:0] seg_d;
    logic [7:0]            hex_q;
    logic [7:0]            hex_d;
    logic [NUM_DIGITS-1:0] blank;
    logic                  zero_above;
    bcd_t                  sel_digit;
    logic                  sel_blank;

    // Strobe prescaler/index next state, leading-zero mask and digit mux
    always_comb begin
        cnt_d      = cnt_q + CNT_W'(1);
        idx_d      = idx_q;
        zero_above = 1'b1;
        blank      = '0;
        sel_digit  = '0;
        sel_blank  = 1'b0;
        if (cnt_q == CNT_W'(STROBE_DIV - 1)) begin
            cnt_d = '0;
            idx_d = (idx_q == IDX_W'(NUM_DIGITS - 1)) ? '0 : idx_q + IDX_W'(1);
        end
        // Walk from the most significant digit down; digit 0 is never blanked
        for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
            zero_above = zero_above && (score[4*(NUM_DIGITS-1-k) +: 4] == 4'd0);
            blank[NUM_DIGITS-1-k] = (BLANK_LZ != 0) && (k != NUM_DIGITS - 1) && zero_above;
        end
        for (int unsigned j = 0; j < NUM_DIGITS; j++) begin
            if (idx_d == IDX_W'(j)) begin
                sel_digit = score[4*j +: 4];
                sel_blank = blank[j];
            end
        end
        seg_d = ~(NUM_DIGITS'(1) << idx_d);
        hex_d = sel_blank ? SEG_BLANK : seg_encode(sel_digit);
    end

    // Select and segment registers both follow the upcoming index value
    always_ff @(posedge CLK) begin
        if (RESET) begin
            cnt_q <= '0;
            idx_q <= '0;
            seg_q <= ~NUM_DIGITS'(1);
            hex_q <= seg_encode(4'd0);
        end else begin
            cnt_q <= cnt_d;
            idx_q <= idx_d;
            seg_q <= seg_d;
            hex_q <= hex_d;
        end
    end

    assign SCORE_BCD      = score;
    assign WIN            = win_q;
    assign OVF            = ovf_q;
    assign SEG_SELECT_OUT = seg_q;
    assign HEX_OUT        = hex_q;

endmodule

// File: tb/tb_score_disp_ctrl.sv
// Directed self-checking bench for score_disp_ctrl: a 4-digit instance with a
// fast strobe, plus 2-digit wrap and saturate instances for overflow.
module tb_score_disp_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst, clr, ate, ate2;

    logic [15:0] score;
    logic        win, ovf;
    logic [3:0]  sel;
    logic [7:0]  hex;

    logic [7:0]  w_score, s_score;
    logic        w_win, w_ovf, s_win, s_ovf;
    logic [1:0]  w_sel, s_sel;
    logic [7:0]  w_hex, s_hex;

    score_disp_ctrl #(.NUM_DIGITS(4), .STROBE_DIV(4), .WIN_SCORE(10), .SAT_MODE(0), .BLANK_LZ(1)) u_dut (
        .CLK(clk), .RESET(rst), .TARGET_ATE(ate), .CLEAR(clr),
        .SCORE_BCD(score), .WIN(win), .OVF(ovf), .SEG_SELECT_OUT(sel), .HEX_OUT(hex)
    );

    score_disp_ctrl #(.NUM_DIGITS(2), .STROBE_DIV(2), .WIN_SCORE(50), .SAT_MODE(0), .BLANK_LZ(1)) u_wrap (
        .CLK(clk), .RESET(rst), .TARGET_ATE(ate2), .CLEAR(clr),
        .SCORE_BCD(w_score), .WIN(w_win), .OVF(w_ovf), .SEG_SELECT_OUT(w_sel), .HEX_OUT(w_hex)
    );

    score_disp_ctrl #(.NUM_DIGITS(2), .STROBE_DIV(2), .WIN_SCORE(50), .SAT_MODE(1), .BLANK_LZ(1)) u_sat (
        .CLK(clk), .RESET(rst), .TARGET_ATE(ate2), .CLEAR(clr),
        .SCORE_BCD(s_score), .WIN(s_win), .OVF(s_ovf), .SEG_SELECT_OUT(s_sel), .HEX_OUT(s_hex)
    );

    int n_cmp = 0;
    int n_bad = 0;
    int mdl;
    int tcnt;
    logic [15:0] exp_q[$];

    // Cycles since reset release: drives the reference strobe position
    always @(posedge clk) begin
        if (rst) tcnt <= 0;
        else     tcnt <= tcnt + 1;
    end

    function automatic logic [15:0] bcd16(input int v);
        logic [15:0] r;
        int t;
        t = v;
        r = '0;
        for (int k = 0; k < 4; k++) begin
            r[4*k +: 4] = 4'(t % 10);
            t = t / 10;
        end
        return r;
    endfunction

    function automatic logic [7:0] seg7(input logic [3:0] d);
        case (d)
            4'd0: return 8'hC0;
            4'd1: return 8'hF9;
            4'd2: return 8'hA4;
            4'd3: return 8'hB0;
            4'd4: return 8'h99;
            4'd5: return 8'h92;
            4'd6: return 8'h82;
            4'd7: return 8'hF8;
            4'd8: return 8'h80;
            4'd9: return 8'h90;
            default: return 8'hFF;
        endcase
    endfunction

    function automatic logic [7:0] exp_hex(input logic [15:0] s, input int idx);
        logic [15:0] upper;
        upper = s >> (4 * idx);
        if (idx > 0 && upper == 16'h0) return 8'hFF;
        return seg7(upper[3:0]);
    endfunction

    function automatic int idx4();
        return (tcnt / 4) % 4;
    endfunction

    function automatic logic [3:0] exp_sel4(input int idx);
        logic [3:0] m;
        m = 4'b0001 << idx;
        return ~m;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic score_pop(input string tag);
        if (exp_q.size() == 0) begin
            n_cmp++;
            n_bad++;
            $error("FAIL %s: observed %h expected <empty scoreboard>", tag, score);
        end else begin
            chk(tag, 32'(score), 32'(exp_q.pop_front()));
        end
    endtask

    // One isolated TARGET_ATE pulse on the 4-digit instance
    task automatic pulse();
        ate = 1'b1;
        mdl++;
        exp_q.push_back(bcd16(mdl));
        tick();
        score_pop("score_inc");
        chk("win_edge", 32'(win), 32'(mdl >= 10));
        ate = 1'b0;
        tick();
    endtask

    task automatic pulse2();
        ate2 = 1'b1;
        tick();
        ate2 = 1'b0;
        tick();
    endtask

    initial begin
        int guard;
        int w_idx;
        rst = 1'b1; clr = 1'b0; ate = 1'b0; ate2 = 1'b0; mdl = 0;
        repeat (3) tick();
        rst = 1'b0;

        // Reset state
        chk("rst_score", 32'(score), 32'h0);
        chk("rst_win",   32'(win),   32'h0);
        chk("rst_ovf",   32'(ovf),   32'h0);
        chk("rst_sel",   32'(sel),   32'hE);
        chk("rst_hex",   32'(hex),   32'hC0);

        // Strobe walk with score 0: only digit 0 lit
        for (int c = 0; c < 20; c++) begin
            tick();
            chk("strobe_sel", 32'(sel), 32'(exp_sel4(idx4())));
            chk("strobe_hex", 32'(hex), 32'(exp_hex(16'h0, idx4())));
        end

        // Level held high scores exactly once, one edge later
        ate = 1'b1;
        mdl = 1;
        exp_q.push_back(bcd16(mdl));
        chk("hold_pre", 32'(score), 32'h0);
        tick();
        score_pop("hold_first");
        repeat (9) begin
            tick();
            chk("hold_level", 32'(score), 32'h0001);
        end
        ate = 1'b0;
        tick();

        // Pulses 2..12; WIN rises with the 10th on the same edge
        for (int p = 0; p < 11; p++) begin
            chk("win_pre", 32'(win), 32'(mdl >= 10));
            pulse();
        end
        chk("score_12", 32'(score), 32'h0012);

        // Display of 0012: two digits lit, upper two blanked
        for (int c = 0; c < 16; c++) begin
            tick();
            chk("disp12_sel", 32'(sel), 32'(exp_sel4(idx4())));
            chk("disp12_hex", 32'(hex), 32'(exp_hex(16'h0012, idx4())));
        end

        // CLEAR zeroes score and WIN
        clr = 1'b1;
        tick();
        clr = 1'b0;
        mdl = 0;
        chk("clr_score", 32'(score), 32'h0);
        chk("clr_win",   32'(win),   32'h0);

        // CLEAR wins over a coincident rising edge at 0005
        repeat (5) pulse();
        chk("score_5", 32'(score), 32'h0005);
        clr = 1'b1;
        ate = 1'b1;
        tick();
        clr = 1'b0;
        chk("clr_prio", 32'(score), 32'h0);
        repeat (4) tick();
        chk("clr_no_late", 32'(score), 32'h0);
        ate = 1'b0;
        tick();
        mdl = 0;

        // Score 0037, then reset while digit 2 is selected
        repeat (37) pulse();
        chk("score_37", 32'(score), 32'h0037);
        guard = 0;
        while (idx4() != 2 && guard < 20) begin
            tick();
            guard++;
        end
        chk("idx2_sel", 32'(sel), 32'hB);
        chk("idx2_hex", 32'(hex), 32'(exp_hex(16'h0037, 2)));
        rst = 1'b1;
        clr = 1'b1;
        ate = 1'b1;
        tick();
        chk("mid_rst_score", 32'(score), 32'h0);
        chk("mid_rst_win",   32'(win),   32'h0);
        chk("mid_rst_sel",   32'(sel),   32'hE);
        chk("mid_rst_hex",   32'(hex),   32'hC0);
        ate = 1'b0;
        clr = 1'b0;
        rst = 1'b0;
        mdl = 0;
        exp_q.delete();
        tick();
        chk("post_rst_score", 32'(score), 32'h0);

        // Two-digit instances: preload to 99
        repeat (99) pulse2();
        chk("w_99",     32'(w_score), 32'h99);
        chk("s_99",     32'(s_score), 32'h99);
        chk("w_win_99", 32'(w_win),   32'h1);
        chk("s_win_99", 32'(s_win),   32'h1);
        chk("w_ovf_99", 32'(w_ovf),   32'h0);

        // Overflow: wrap instance rolls to 00 with a one-cycle OVF, saturate holds
        ate2 = 1'b1;
        tick();
        chk("w_wrap",     32'(w_score), 32'h00);
        chk("w_ovf",      32'(w_ovf),   32'h1);
        chk("w_win_wrap", 32'(w_win),   32'h1);
        chk("s_hold",     32'(s_score), 32'h99);
        chk("s_ovf",      32'(s_ovf),   32'h0);
        ate2 = 1'b0;
        tick();
        chk("w_ovf_end",  32'(w_ovf),   32'h0);
        chk("s_ovf_end",  32'(s_ovf),   32'h0);

        pulse2();
        tick();
        chk("w_after_wrap", 32'(w_score), 32'h01);
        w_idx = (tcnt / 2) % 2;
        chk("w_sel", 32'(w_sel), (w_idx == 0) ? 32'h2 : 32'h1);
        chk("w_hex", 32'(w_hex), (w_idx == 0) ? 32'hF9 : 32'hFF);
        chk("s_sel", 32'(s_sel), (w_idx == 0) ? 32'h2 : 32'h1);
        chk("s_hex", 32'(s_hex), 32'h90);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
